// File: rtl/tpu_mac_pkg.sv
// Shared types and constants for the TPU MAC dot-product sequencer.
package tpu_mac_pkg;

    // Encodings of the operand data type, forwarded unchanged to the MAC.
    localparam logic [2:0] DT_INT8  = 3'b000;
    localparam logic [2:0] DT_INT16 = 3'b001;
    localparam logic [2:0] DT_INT32 = 3'b010;

    // Sequencer states. The names are in capitals, so WAIT does not collide with the 'wait' keyword.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tpu_mac_dot_sequencer.sv
// Drives one external MAC unit through a dot product over a streamed vector.
// Each accepted operand pair becomes one MAC operation. The MAC result is fed
// back as c_data for the next pair. The final sum is reported with a done pulse.
module tpu_mac_dot_sequencer
    import tpu_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic [2:0]            data_type,
    input  logic [DATA_WIDTH-1:0] init_acc,
    input  logic                  abort,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [OP_WIDTH-1:0]   op_a,
    input  logic [OP_WIDTH-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] dot_result,
    output logic [LEN_WIDTH-1:0]  elem_count,
    output logic                  mac_enable,
    output logic [2:0]            mac_data_type,
    output logic [OP_WIDTH-1:0]   mac_a,
    output logic [OP_WIDTH-1:0]   mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    output logic                  mac_valid_in,
    input  logic [DATA_WIDTH-1:0] mac_result,
    input  logic                  mac_valid_out,
    input  logic                  mac_ready
);

    localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

    seq_state_t            state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] acc;
    logic                  err_flag;
    logic [WD_WIDTH-1:0]   watchdog;

    // The running accumulator is the MAC's c operand.
    assign mac_c = acc;

    // Issue strobe: valid_in is asserted only in a cycle in which the MAC reports ready.
    // A simultaneous abort suppresses it, so no operation is left in flight.
    assign mac_valid_in = (state == ISSUE) && mac_ready && !abort;

    // Sequencer FSM. All other outputs are registered here together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len_q         <= '0;
            acc           <= '0;
            err_flag      <= 1'b0;
            watchdog      <= '0;
            op_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            dot_result    <= '0;
            elem_count    <= '0;
            mac_enable    <= 1'b0;
            mac_data_type <= '0;
            mac_a         <= '0;
            mac_b         <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge
            // state. The pulse defaults below are simply overridden later in the block.
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q         <= vec_len;
                        mac_data_type <= data_type;
                        acc           <= init_acc;
                        elem_count    <= '0;
                        err_flag      <= 1'b0;
                        busy          <= 1'b1;
                        mac_enable    <= 1'b1;
                        if (vec_len != '0) begin
                            state    <= FETCH;
                            op_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        err_flag <= 1'b1;
                        op_ready <= 1'b0;
                        state    <= DONE;
                    end else if (op_valid && op_ready) begin
                        mac_a    <= op_a;
                        mac_b    <= op_b;
                        op_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end else if (mac_ready) begin
                        watchdog <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Abort has priority, so a MAC result in the abort cycle is dropped.
                    if (abort) begin
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end else if (mac_valid_out) begin
                        acc        <= mac_result;
                        elem_count <= elem_count + 1'b1;
                        if (elem_count + 1'b1 == len_q) begin
                            state <= DONE;
                        end else begin
                            op_ready <= 1'b1;
                            state    <= FETCH;
                        end
                    end else if (watchdog == WD_LAST) begin
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                DONE: begin
                    dot_result <= acc;
                    done       <= 1'b1;
                    error      <= err_flag;
                    busy       <= 1'b0;
                    mac_enable <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_mac_dot_sequencer.sv
// Randomised bench for tpu_mac_dot_sequencer. It uses a behavioural MAC model,
// and each job's expected sum is computed as plain arithmetic over the operand table.
module tb_tpu_mac_dot_sequencer;
    import tpu_mac_pkg::*;

    localparam int DW      = 32;
    localparam int OW      = 16;
    localparam int LW      = 8;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic [2:0]    data_type = '0;
    logic [DW-1:0] init_acc = '0;
    logic          abort = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [OW-1:0] op_a = '0;
    logic [OW-1:0] op_b = '0;
    logic          busy, done, error;
    logic [DW-1:0] dot_result;
    logic [LW-1:0] elem_count;
    logic          mac_enable;
    logic [2:0]    mac_data_type;
    logic [OW-1:0] mac_a, mac_b;
    logic [DW-1:0] mac_c;
    logic          mac_valid_in;
    logic [DW-1:0] mac_result = '0;
    logic          mac_valid_out = 1'b0;
    logic          mac_ready = 1'b1;

    always #5 clk = ~clk;

    tpu_mac_dot_sequencer #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .LEN_WIDTH(LW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .data_type(data_type),
        .init_acc(init_acc), .abort(abort), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .error(error),
        .dot_result(dot_result), .elem_count(elem_count), .mac_enable(mac_enable),
        .mac_data_type(mac_data_type), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_valid_in(mac_valid_in), .mac_result(mac_result), .mac_valid_out(mac_valid_out),
        .mac_ready(mac_ready)
    );

    int checks = 0;
    int failures = 0;

    // Operand table for the current job.
    logic [OW-1:0] pa [0:15];
    logic [OW-1:0] pb [0:15];

    // MAC model configuration. special_lat = 0 means the MAC never answers that issue.
    int mac_lat = 1;
    int special_issue = -1;
    int special_lat = 0;

    // Counters written only by the model/monitor process.
    int issue_cnt = 0, done_cnt = 0, op_ready_cnt = 0, ready_viol = 0, err_solo = 0;
    int m_cnt = 0;
    bit m_busy = 1'b0;
    logic [DW-1:0] m_res = '0;

    // Signed product, as the MAC computes it for each data type.
    function automatic longint prod(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic [2:0] dt);
        logic signed [7:0]  a8, b8;
        logic signed [15:0] a16, b16;
        a8 = a[7:0]; b8 = b[7:0]; a16 = a; b16 = b;
        if (dt == DT_INT8) return longint'(a8) * longint'(b8);
        return longint'(a16) * longint'(b16);
    endfunction

    // Reference: init + sum of the first n products, modulo 2^DW.
    function automatic logic [DW-1:0] ref_dot(input int n, input logic [2:0] dt, input logic [DW-1:0] init);
        longint s;
        s = longint'(init);
        for (int i = 0; i < n; i++) s = s + prod(pa[i], pb[i], dt);
        return DW'(s);
    endfunction

    // Behavioural MAC plus monitor. It runs 2 time units after each falling edge,
    // away from both clock edges.
    always @(negedge clk) begin
        #2;
        mac_valid_out = 1'b0;
        if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                mac_valid_out = 1'b1;
                mac_result    = m_res;
                m_busy        = 1'b0;
            end
        end
        if (mac_valid_in) begin
            issue_cnt = issue_cnt + 1;
            if (!mac_ready) ready_viol = ready_viol + 1;
            m_res  = DW'(longint'(mac_c) + prod(mac_a, mac_b, mac_data_type));
            m_cnt  = (issue_cnt == special_issue) ? special_lat : mac_lat;
            m_busy = (m_cnt != 0);
        end
        if (op_ready) op_ready_cnt = op_ready_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (error && !done) err_solo = err_solo + 1;
    end

    task automatic start_job(input int len, input logic [2:0] dt, input logic [DW-1:0] init);
        @(negedge clk);
        start = 1'b1; vec_len = LW'(len); data_type = dt; init_acc = init;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one pair after 'gap' idle cycles. Optionally hold mac_ready low for three ISSUE cycles.
    task automatic send_pair(input logic [OW-1:0] a, input logic [OW-1:0] b, input int gap, input bit stall);
        int n;
        op_valid = 1'b0;
        repeat (gap) @(negedge clk);
        op_valid = 1'b1; op_a = a; op_b = b;
        n = 0;
        while (!op_ready && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (op_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake op_ready=%b required=1", op_ready);
        end
        if (stall) mac_ready = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        if (stall) begin
            repeat (3) @(negedge clk);
            mac_ready = 1'b1;
        end
    endtask

    task automatic wait_done(input int bound, output bit seen, output logic [DW-1:0] res, output logic err,
                             output logic [LW-1:0] cnt, output logic bsy, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < bound) begin @(negedge clk); cycles++; end
        seen = (done === 1'b1); res = dot_result; err = error; cnt = elem_count; bsy = busy;
    endtask

    // Run one complete job against the reference and check all its outcomes.
    task automatic run_job(input string name, input int len, input logic [2:0] dt, input logic [DW-1:0] init,
                           input int gap, input int stall_idx);
        int d0, i0, v0, cyc, g;
        bit seen;
        logic [DW-1:0] res, expv;
        logic e, b;
        logic [LW-1:0] cnt;
        expv = ref_dot(len, dt, init);
        d0 = done_cnt; i0 = issue_cnt; v0 = ready_viol;
        start_job(len, dt, init);
        for (int i = 0; i < len; i++) begin
            g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            send_pair(pa[i], pb[i], g, i == stall_idx);
        end
        wait_done(1000, seen, res, e, cnt, b, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL %s done_seen got=0 want=1", name); end
        checks++;
        if (res !== expv) begin failures++; $display("FAIL %s dot_result got=%0d want=%0d", name, res, expv); end
        checks++;
        if (cnt !== LW'(len)) begin failures++; $display("FAIL %s elem_count got=%0d want=%0d", name, cnt, len); end
        checks++;
        if (e !== 1'b0 || b !== 1'b0) begin failures++; $display("FAIL %s error/busy got=%b/%b want=0/0", name, e, b); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b want=0", name, done); end
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt - d0); end
        checks++;
        if (issue_cnt - i0 != len) begin failures++; $display("FAIL %s mac_issues got=%0d want=%0d", name, issue_cnt - i0, len); end
        checks++;
        if (ready_viol != v0) begin failures++; $display("FAIL %s valid_without_ready got=%0d want=0", name, ready_viol - v0); end
    endtask

    task automatic load_spec_pairs();
        pa[0] = 16'd10; pb[0] = 16'd20;
        pa[1] = 16'd7;  pb[1] = 16'd8;
        pa[2] = 16'd15; pb[2] = 16'd4;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, op_ready, mac_enable, mac_valid_in, dot_result, elem_count,
             mac_a, mac_b, mac_c, mac_data_type} !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b op_ready=%b mac_enable=%b dot_result=%0h want all 0",
                     busy, done, op_ready, mac_enable, dot_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_int8();
        load_spec_pairs();
        mac_lat = 2;
        run_job("basic_int8", 3, DT_INT8, 32'd5, 0, -1);
    endtask

    task automatic test_zero_len();
        int i0, r0;
        i0 = issue_cnt; r0 = op_ready_cnt;
        start_job(0, DT_INT8, 32'd42);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL zero_len early_done got=%b want=0", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || dot_result !== 32'd42 || error !== 1'b0) begin
            failures++;
            $display("FAIL zero_len done/result/error got=%b/%0d/%b want=1/42/0", done, dot_result, error);
        end
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (issue_cnt != i0 || op_ready_cnt != r0) begin
            failures++;
            $display("FAIL zero_len issues/op_ready_cycles got=%0d/%0d want=0/0", issue_cnt - i0, op_ready_cnt - r0);
        end
    endtask

    task automatic test_gaps_and_stall();
        load_spec_pairs();
        mac_lat = 3;
        run_job("gaps_stall", 3, DT_INT8, 32'd5, 7, 1);
    endtask

    task automatic test_timeout();
        int d0, s0, cyc;
        bit seen;
        logic [DW-1:0] res, expv;
        logic e, b;
        logic [LW-1:0] cnt;
        load_spec_pairs();
        mac_lat = 1;
        expv = ref_dot(1, DT_INT8, 32'd5);
        d0 = done_cnt; s0 = err_solo;
        special_issue = issue_cnt + 2;
        special_lat   = TIMEOUT + 8;
        start_job(3, DT_INT8, 32'd5);
        send_pair(pa[0], pb[0], 0, 1'b0);
        send_pair(pa[1], pb[1], 0, 1'b0);
        // Now in the issue cycle of element 2. The pulse lags the 64-cycle WAIT by the DONE cycle.
        wait_done(TIMEOUT + 20, seen, res, e, cnt, b, cyc);
        checks++;
        if (!seen || cyc != TIMEOUT + 2) begin
            failures++;
            $display("FAIL timeout done_latency seen=%b got=%0d want=%0d", seen, cyc, TIMEOUT + 2);
        end
        checks++;
        if (e !== 1'b1 || res !== expv || cnt !== 8'd1 || b !== 1'b0) begin
            failures++;
            $display("FAIL timeout error/result/count/busy got=%b/%0d/%0d/%b want=1/%0d/1/0", e, res, cnt, b, expv);
        end
        repeat (15) @(negedge clk);
        #3;
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || dot_result !== expv || elem_count !== 8'd1 || err_solo != s0) begin
            failures++;
            $display("FAIL timeout late_result_ignored pulses=%0d busy=%b result=%0d count=%0d want 1/0/%0d/1",
                     done_cnt - d0, busy, dot_result, elem_count, expv);
        end
        special_issue = -1;
    endtask

    task automatic test_abort_and_restart_ignored();
        int d0, i0, cyc;
        bit seen;
        logic [DW-1:0] res, expv;
        logic e, b;
        logic [LW-1:0] cnt;
        load_spec_pairs();
        mac_lat = 2;
        expv = ref_dot(1, DT_INT8, 32'd5);
        d0 = done_cnt; i0 = issue_cnt;
        special_issue = issue_cnt + 2;
        special_lat   = 1;
        start_job(3, DT_INT8, 32'd5);
        send_pair(pa[0], pb[0], 0, 1'b0);
        // A second start while the job is running must be ignored.
        start = 1'b1; vec_len = '0; init_acc = 32'd999;
        @(negedge clk);
        start = 1'b0;
        send_pair(pa[1], pb[1], 0, 1'b0);
        @(negedge clk);
        // The MAC answers in this same cycle. Abort must win, and the result is discarded.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(10, seen, res, e, cnt, b, cyc);
        checks++;
        if (!seen || cyc != 1) begin failures++; $display("FAIL abort done_latency seen=%b got=%0d want=1", seen, cyc); end
        checks++;
        if (e !== 1'b1 || res !== expv || cnt !== 8'd1 || b !== 1'b0) begin
            failures++;
            $display("FAIL abort error/result/count/busy got=%b/%0d/%0d/%b want=1/%0d/1/0", e, res, cnt, b, expv);
        end
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (done_cnt - d0 != 1 || issue_cnt - i0 != 2) begin
            failures++;
            $display("FAIL abort pulses/issues got=%0d/%0d want=1/2", done_cnt - d0, issue_cnt - i0);
        end
        special_issue = -1;
    endtask

    task automatic test_reset_mid_fetch();
        int d0;
        d0 = done_cnt;
        start_job(3, DT_INT8, 32'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, op_ready, mac_enable, mac_valid_in, dot_result, elem_count, mac_c} !== '0) begin
            failures++;
            $display("FAIL async_reset busy=%b op_ready=%b mac_enable=%b mac_c=%0h want all 0",
                     busy, op_ready, mac_enable, mac_c);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL async_reset done_pulses got=%0d want=0", done_cnt - d0); end
        pa[0] = 16'd0; pb[0] = 16'd999;
        mac_lat = 1;
        run_job("after_reset", 1, DT_INT16, 32'd42, 0, -1);
    endtask

    task automatic test_random();
        int len, stall;
        logic [2:0] dt;
        for (int j = 0; j < 8; j++) begin
            len = int'($urandom_range(1, 8));
            case ($urandom_range(0, 2))
                0: dt = DT_INT8;
                1: dt = DT_INT16;
                default: dt = DT_INT32;
            endcase
            for (int i = 0; i < len; i++) begin
                pa[i] = OW'($urandom);
                pb[i] = OW'($urandom);
            end
            mac_lat = int'($urandom_range(1, 4));
            stall = int'($urandom_range(0, 9));
            run_job("random", len, dt, DW'($urandom), -1, stall);
        end
    endtask

    initial begin
        test_reset();
        test_basic_int8();
        test_zero_len();
        test_gaps_and_stall();
        test_timeout();
        test_abort_and_restart_ignored();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tpu_mac_dot_sequencer.md
Name: tpu_mac_dot_sequencer

Overview:
Controller that drives a single TPU MAC unit to compute a dot product over a streamed vector of operand pairs.
- Accepts a job (length, data type, initial accumulator) and pulls operand pairs over a valid/ready stream.
- Issues one MAC per pair and chains each MAC result back as c_data for the next MAC.
- Reports the final sum with a done pulse.
- Sits between the accelerator command/DMA front end and the MAC datapath, and owns the MAC's enable/valid_in/c_data.

Parameters:
- DATA_WIDTH, 32, accumulator/result width (matches MAC DATA_WIDTH).
- OP_WIDTH, 16, operand width of a_data/b_data.
- LEN_WIDTH, 8, width of vec_len; maximum length is 2^LEN_WIDTH-1.
- TIMEOUT, 64, max cycles to wait for mac_valid_out before flagging error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle job start, sampled only in IDLE
- vec_len  in  LEN_WIDTH  number of operand pairs; 0 allowed
- data_type  in  3  000 INT8, 001 INT16, 010 INT32; latched at start
- init_acc  in  DATA_WIDTH  initial accumulator value; latched at start
- abort  in  1  cancel the current job
- op_valid  in  1  operand pair valid
- op_ready  out  1  sequencer accepts a pair this cycle
- op_a  in  OP_WIDTH  operand A
- op_b  in  OP_WIDTH  operand B
- busy  out  1  job in progress (not IDLE)
- done  out  1  one-cycle pulse; result valid
- error  out  1  one-cycle pulse, coincident with done, on MAC timeout or abort
- dot_result  out  DATA_WIDTH  final accumulator; held until next start
- elem_count  out  LEN_WIDTH  pairs completed in the current/last job
- mac_enable  out  1  MAC enable
- mac_data_type  out  3  to MAC data_type
- mac_a  out  OP_WIDTH  to MAC a_data
- mac_b  out  OP_WIDTH  to MAC b_data
- mac_c  out  DATA_WIDTH  to MAC c_data (running accumulator)
- mac_valid_in  out  1  to MAC valid_in
- mac_result  in  DATA_WIDTH  from MAC result
- mac_valid_out  in  1  from MAC valid_out
- mac_ready  in  1  from MAC ready

Behaviour:

Reset values:
- All outputs 0, state IDLE, accumulator 0.
- Reset asserted mid-job returns to IDLE immediately with no done pulse.

IDLE:
- busy=0, op_ready=0, mac_enable=0.
- start=1 latches vec_len, data_type and init_acc, clears elem_count, sets acc=init_acc.
- Next state: FETCH if vec_len!=0, else DONE.

FETCH:
- busy=1, mac_enable=1, op_ready=1.
- On op_valid&&op_ready, register op_a and op_b, then go to ISSUE.
- op_valid gaps are tolerated indefinitely (no timeout in FETCH).

ISSUE:
- op_ready=0.
- When mac_ready=1, drive mac_valid_in=1 for exactly one cycle with mac_a/b registered, mac_c=acc, mac_data_type latched. Then go to WAIT and clear the watchdog.
- If mac_ready=0, stay in ISSUE with mac_valid_in=0.

WAIT:
- The watchdog increments each cycle.
- On mac_valid_out: acc<=mac_result (full DATA_WIDTH, no saturation, wraps modulo 2^DATA_WIDTH as the MAC does) and elem_count++. Go to DONE if elem_count+1==vec_len, else FETCH.
- If the watchdog reaches TIMEOUT: set the error flag and go to DONE.

DONE:
- dot_result<=acc. done=1 for one cycle; error=1 in the same cycle if flagged. Then go to IDLE.
- mac_enable drops in IDLE.

Abort:
- In FETCH, ISSUE or WAIT, abort=1 sets the error flag and goes to DONE next cycle.
- dot_result = acc (partial sum so far); a MAC result arriving in that same cycle is discarded.
- abort in IDLE or DONE is ignored.

Other rules:
- start while busy is ignored; the running job is unaffected.
- Latency per element: 1 (FETCH, if op_valid is already high) + 1 (ISSUE, if ready) + MAC latency.
- vec_len=0: done two cycles after start (IDLE→DONE→pulse), dot_result=init_acc.
- Only one MAC operation is outstanding at any time.
- A mac_valid_out arriving outside WAIT is ignored.

Decomposition:
- Package tpu_mac_pkg:
  - data type constants DT_INT8=3'b000, DT_INT16=3'b001, DT_INT32=3'b010
  - state enum seq_state_t {IDLE, FETCH, ISSUE, WAIT, DONE}
- The MAC datapath stays external; the sequencer connects to simple_tpu_mac at integration.
- No sub-module; the watchdog is an inline counter.

Test Plan:
- INT8, init_acc=5, pairs (10,20),(7,8),(15,4) with a behavioural or real MAC → done pulse once, dot_result=321, elem_count=3, error=0, exactly 3 mac_valid_in pulses.
- vec_len=0, init_acc=42 → done two cycles after start, dot_result=42, no mac_valid_in, op_ready never high.
- op_valid deasserted for 7 cycles between pairs, and mac_ready low for 3 cycles before an issue → same result 321, no duplicated or dropped pairs, mac_valid_in only while mac_ready=1.
- MAC model never asserts valid_out on the 2nd element (TIMEOUT=64) → done and error pulse together 64 cycles into WAIT, dot_result=205 (partial), busy=0 after.
- abort asserted in WAIT of element 2 of the 3-element job → done+error next cycle, dot_result=205, the late mac_valid_out is ignored. A second start during a running job changes nothing.
- rst_n dropped mid-FETCH → all outputs 0 asynchronously, no done. A fresh job afterwards completes correctly (0*999+42 → 42).
